// File: rtl/date_string_tx.sv
// date_string_tx: formats a binary year/month/day plus separator select into
// an ASCII date string ("2021.10.26") and streams it out one byte per
// valid/ready transfer.
// Optional build macro DATE_PAD_EN: fixed-width fields with leading '0'
// (YYYY?MM?DD, always 10 bytes). Undefined: no leading zeros.
module date_string_tx #(
    parameter int YEAR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [YEAR_W-1:0] year,
    input  logic [3:0]        month,
    input  logic [4:0]        day,
    input  logic [1:0]        sep_sel,
    output logic [7:0]        out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        YEAR  = 3'd2,
        SEP1  = 3'd3,
        MONTH = 3'd4,
        SEP2  = 3'd5,
        DAY   = 3'd6
    } state_t;

    state_t            state;
    logic [YEAR_W-1:0] year_r;
    logic [3:0]        month_r;
    logic [4:0]        day_r;
    logic [1:0]        sep_r;
    logic [15:0]       y_bcd;
    logic [7:0]        m_bcd;
    logic [7:0]        d_bcd;
    logic              m_start;
    logic              d_start;
    logic [1:0]        idx;

    logic              fields_legal;
    logic              xfer;
    logic [3:0]        y_th, y_h, y_t, y_o, d_t, d_o;
    logic [15:0]       y_bcd_c;
    logic [7:0]        m_bcd_c;
    logic [7:0]        d_bcd_c;
    logic [1:0]        y_start_c;
    logic              m_start_c;
    logic              d_start_c;

    // ASCII code of a single decimal digit
    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Year digit i of four, i = 0 is the thousands digit
    function automatic logic [3:0] year_digit(input logic [15:0] bcd, input logic [1:0] i);
        logic [3:0] d;
        case (i)
            2'd0:    d = bcd[15:12];
            2'd1:    d = bcd[11:8];
            2'd2:    d = bcd[7:4];
            default: d = bcd[3:0];
        endcase
        return d;
    endfunction

    // Separator byte; code 3 never reaches here because it is rejected at start
    function automatic logic [7:0] sep_char(input logic [1:0] s);
        logic [7:0] c;
        case (s)
            2'd0:    c = 8'h2E;
            2'd1:    c = 8'h2D;
            2'd2:    c = 8'h2F;
            default: c = 8'h2E;
        endcase
        return c;
    endfunction

    assign xfer = out_valid && out_ready;

    // Field legality check on the live inputs, used when start is sampled in IDLE
    always_comb begin
        fields_legal = (year != '0) && (year <= YEAR_W'(9999)) &&
                       (month != 4'd0) && (month <= 4'd12) &&
                       (day != 5'd0) && (sep_sel != 2'd3);
    end

    // Binary-to-BCD conversion and first-digit index of the latched fields
    always_comb begin
        y_th    = 4'(year_r / YEAR_W'(1000));
        y_h     = 4'((year_r / YEAR_W'(100)) % YEAR_W'(10));
        y_t     = 4'((year_r / YEAR_W'(10)) % YEAR_W'(10));
        y_o     = 4'(year_r % YEAR_W'(10));
        d_t     = 4'(day_r / 5'd10);
        d_o     = 4'(day_r % 5'd10);
        y_bcd_c = {y_th, y_h, y_t, y_o};
        d_bcd_c = {d_t, d_o};
        if (month_r >= 4'd10) begin
            m_bcd_c = {4'd1, month_r - 4'd10};
        end else begin
            m_bcd_c = {4'd0, month_r};
        end
`ifdef DATE_PAD_EN
        y_start_c = 2'd0;
        m_start_c = 1'b0;
        d_start_c = 1'b0;
`else
        if (year_r >= YEAR_W'(1000)) begin
            y_start_c = 2'd0;
        end else if (year_r >= YEAR_W'(100)) begin
            y_start_c = 2'd1;
        end else if (year_r >= YEAR_W'(10)) begin
            y_start_c = 2'd2;
        end else begin
            y_start_c = 2'd3;
        end
        m_start_c = (month_r < 4'd10);
        d_start_c = (day_r < 5'd10);
`endif
    end

    // Control FSM; every output is registered and idx walks digits MSD first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            year_r    <= '0;
            month_r   <= 4'd0;
            day_r     <= 5'd0;
            sep_r     <= 2'd0;
            y_bcd     <= 16'h0000;
            m_bcd     <= 8'h00;
            d_bcd     <= 8'h00;
            m_start   <= 1'b0;
            d_start   <= 1'b0;
            idx       <= 2'd0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    out_valid <= 1'b0;
                    if (start) begin
                        if (fields_legal) begin
                            year_r  <= year;
                            month_r <= month;
                            day_r   <= day;
                            sep_r   <= sep_sel;
                            busy    <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    y_bcd     <= y_bcd_c;
                    m_bcd     <= m_bcd_c;
                    d_bcd     <= d_bcd_c;
                    m_start   <= m_start_c;
                    d_start   <= d_start_c;
                    idx       <= y_start_c;
                    out_char  <= digit_char(year_digit(y_bcd_c, y_start_c));
                    out_valid <= 1'b1;
                    state     <= YEAR;
                end
                YEAR: begin
                    if (xfer) begin
                        if (idx == 2'd3) begin
                            out_char <= sep_char(sep_r);
                            state    <= SEP1;
                        end else begin
                            idx      <= idx + 2'd1;
                            out_char <= digit_char(year_digit(y_bcd, idx + 2'd1));
                        end
                    end
                end
                SEP1: begin
                    if (xfer) begin
                        idx      <= {1'b0, m_start};
                        out_char <= digit_char(m_start ? m_bcd[3:0] : m_bcd[7:4]);
                        state    <= MONTH;
                    end
                end
                MONTH: begin
                    if (xfer) begin
                        if (idx[0]) begin
                            out_char <= sep_char(sep_r);
                            state    <= SEP2;
                        end else begin
                            idx      <= 2'd1;
                            out_char <= digit_char(m_bcd[3:0]);
                        end
                    end
                end
                SEP2: begin
                    if (xfer) begin
                        idx      <= {1'b0, d_start};
                        out_char <= digit_char(d_start ? d_bcd[3:0] : d_bcd[7:4]);
                        state    <= DAY;
                    end
                end
                DAY: begin
                    if (xfer) begin
                        if (idx[0]) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            idx      <= 2'd1;
                            out_char <= digit_char(d_bcd[3:0]);
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_date_string_tx.sv
// Directed self-checking bench for date_string_tx.
module tb_date_string_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] year;
    logic [3:0]  month;
    logic [4:0]  day;
    logic [1:0]  sep_sel;
    logic [7:0]  out_char;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap [0:15];
    int cap_n, cap_stall, cap_done, cap_gap, cap_first, cap_iters, cap_err;

    date_string_tx #(.YEAR_W(14)) dut (
        .clk(clk), .reset(reset), .start(start), .year(year), .month(month),
        .day(day), .sep_sel(sep_sel), .out_char(out_char), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Drive a one-cycle start; returns at the negedge after it was sampled
    task automatic issue(input logic [13:0] y, input logic [3:0] m, input logic [4:0] d, input logic [1:0] s);
        year = y; month = m; day = d; sep_sel = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sink model: drives out_ready (mode 0 always 1, mode 1 pattern 1,0,0 per valid cycle)
    // and records transferred bytes until done or the cycle budget expires
    task automatic capture(input int mode, input int max_cycles);
        int k;
        logic held_v;
        logic [7:0] held;
        k = 0; held_v = 1'b0; held = 8'h00;
        cap_n = 0; cap_stall = 0; cap_done = 0; cap_gap = 0; cap_first = -1; cap_iters = 0; cap_err = 0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            cap_iters = c + 1;
            if (err) cap_err++;
            if (done) begin
                cap_done = 1;
                break;
            end
            if (held_v && !out_valid) cap_stall++;
            if (out_valid) begin
                if (cap_first < 0) cap_first = c;
                if (held_v && out_char !== held) cap_stall++;
                out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
                k++;
                if (out_ready) begin
                    if (cap_n < 16) cap[cap_n] = out_char;
                    cap_n++;
                    held_v = 1'b0;
                end else begin
                    held_v = 1'b1;
                    held = out_char;
                end
            end else if (cap_n > 0) begin
                cap_gap++;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; out_ready = 1'b1;
        year = 14'd0; month = 4'd0; day = 5'd0; sep_sel = 2'd0;
        #1 reset = 1'b1;
        @(negedge clk);
        checks++; if (out_char !== 8'h00) begin errors++; $display("FAIL reset_out_char got %h want 00", out_char); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        string exp = "2021.10.26";
        issue(14'd2021, 4'd10, 5'd26, 2'd0);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL basic_load got valid=%b busy=%b want valid=0 busy=1", out_valid, busy); end
        capture(0, 40);
        checks++; if (cap_done !== 1) begin errors++; $display("FAIL basic_done_seen got %0d want 1", cap_done); end
        checks++; if (cap_first !== 0) begin errors++; $display("FAIL basic_latency got %0d want 0", cap_first); end
        checks++; if (cap_gap !== 0) begin errors++; $display("FAIL basic_gap got %0d want 0", cap_gap); end
        checks++; if (cap_iters !== 11) begin errors++; $display("FAIL basic_cycles got %0d want 11", cap_iters); end
        checks++; if (cap_n !== exp.len()) begin errors++; $display("FAIL basic_len got %0d want %0d", cap_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, cap[i], exp[i]); end
        end
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_end got busy=%b valid=%b want 0 0", busy, out_valid); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_short;
`ifdef DATE_PAD_EN
        string exp = "0007/03/05";
`else
        string exp = "7/3/5";
`endif
        issue(14'd7, 4'd3, 5'd5, 2'd2);
        capture(0, 40);
        checks++; if (cap_done !== 1) begin errors++; $display("FAIL short_done_seen got %0d want 1", cap_done); end
        checks++; if (cap_n !== exp.len()) begin errors++; $display("FAIL short_len got %0d want %0d", cap_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL short_byte%0d got %h want %h", i, cap[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure;
        string exp = "1999-12-31";
        issue(14'd1999, 4'd12, 5'd31, 2'd1);
        capture(1, 200);
        checks++; if (cap_done !== 1) begin errors++; $display("FAIL bp_done_seen got %0d want 1", cap_done); end
        checks++; if (cap_stall !== 0) begin errors++; $display("FAIL bp_stall_stable got %0d want 0", cap_stall); end
        checks++; if (cap_n !== exp.len()) begin errors++; $display("FAIL bp_len got %0d want %0d", cap_n, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, cap[i], exp[i]); end
        end
    endtask

    task automatic test_illegal;
        logic [13:0] ys [0:3];
        logic [3:0]  ms [0:3];
        logic [4:0]  ds [0:3];
        logic [1:0]  ss [0:3];
        ys = '{14'd2021, 14'd2021, 14'd2021, 14'd10000};
        ms = '{4'd13, 4'd5, 4'd5, 4'd5};
        ds = '{5'd10, 5'd0, 5'd10, 5'd10};
        ss = '{2'd0, 2'd0, 2'd3, 2'd0};
        for (int v = 0; v < 4; v++) begin
            issue(ys[v], ms[v], ds[v], ss[v]);
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal%0d_err got %b want 1", v, err); end
            checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL illegal%0d_idle got busy=%b valid=%b want 0 0", v, busy, out_valid); end
            @(negedge clk);
            checks++; if (err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL illegal%0d_after got err=%b busy=%b valid=%b want 0 0 0", v, err, busy, out_valid); end
        end
    endtask

    task automatic test_reset_mid;
        string exp = "2021.10.26";
        int n = 0;
        issue(14'd2021, 4'd10, 5'd26, 2'd0);
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL rstmid_bytes got %0d want 4", n); end
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got busy=%b valid=%b want 1 1", busy, out_valid); end
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_async got valid=%b busy=%b want 0 0", out_valid, busy); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(14'd2021, 4'd10, 5'd26, 2'd0);
        capture(0, 40);
        checks++; if (cap_n !== exp.len() || cap_done !== 1) begin errors++; $display("FAIL rstmid_len got %0d done=%0d want %0d done=1", cap_n, cap_done, exp.len()); end
        for (int i = 0; i < exp.len(); i++) begin
            checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, cap[i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back;
`ifdef DATE_PAD_EN
        string exp1 = "0007/03/05";
        string exp2 = "0012-11-09";
`else
        string exp1 = "7/3/5";
        string exp2 = "12-11-9";
`endif
        issue(14'd7, 4'd3, 5'd5, 2'd2);
        // start held high with different fields while busy: must be ignored
        year = 14'd1234; month = 4'd5; day = 5'd6; sep_sel = 2'd0; start = 1'b1;
        capture(0, 40);
        checks++; if (cap_err !== 0) begin errors++; $display("FAIL b2b_busy_err got %0d want 0", cap_err); end
        checks++; if (cap_n !== exp1.len() || cap_done !== 1) begin errors++; $display("FAIL b2b_len1 got %0d done=%0d want %0d done=1", cap_n, cap_done, exp1.len()); end
        for (int i = 0; i < exp1.len(); i++) begin
            checks++; if (cap[i] !== exp1[i]) begin errors++; $display("FAIL b2b_s1_byte%0d got %h want %h", i, cap[i], exp1[i]); end
        end
        // in the done cycle: present new fields with start still high
        year = 14'd12; month = 4'd11; day = 5'd9; sep_sel = 2'd1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_load got busy=%b valid=%b want 1 0", busy, out_valid); end
        capture(0, 40);
        checks++; if (cap_first !== 0) begin errors++; $display("FAIL b2b_latency got %0d want 0", cap_first); end
        checks++; if (cap_n !== exp2.len() || cap_done !== 1) begin errors++; $display("FAIL b2b_len2 got %0d done=%0d want %0d done=1", cap_n, cap_done, exp2.len()); end
        for (int i = 0; i < exp2.len(); i++) begin
            checks++; if (cap[i] !== exp2[i]) begin errors++; $display("FAIL b2b_s2_byte%0d got %h want %h", i, cap[i], exp2[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/date_string_tx.md
Name: date_string_tx

Overview:
- Transmitter counterpart of the team's serial date-string recognizer. Takes a binary year/month/day plus a separator select, and emits the ASCII date string one byte per transfer.
- Output format: year, sep, month, sep, day. Example: "2021.10.26".
- Output bytes are valid/ready handshaked. Sits upstream of the recognizer, or any byte-serial text sink, as a stimulus/formatter source.

Parameters:
- YEAR_W, 14, width of year input (max representable 16383; legal range 1..9999)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- start  input  1  request to format fields; sampled only in IDLE
- year  input  YEAR_W  binary year, legal 1..9999
- month  input  4  binary month, legal 1..12
- day  input  5  binary day, legal 1..31
- sep_sel  input  2  0='.'(0x2E), 1='-'(0x2D), 2='/'(0x2F), 3=illegal
- out_char  output  8  current ASCII byte
- out_valid  output  1  out_char is valid
- out_ready  input  1  sink accepts out_char when out_valid&&out_ready at rising edge
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after last byte transferred
- err  output  1  one-cycle pulse on rejected start

Behaviour:
- Reset values: out_char=8'h00, out_valid=0, busy=0, done=0, err=0; state=IDLE. Async reset mid-string drops out_valid at once; no partial resume.
- States: IDLE, LOAD, YEAR, SEP1, MONTH, SEP2, DAY.
- IDLE:
  - start=1 with all fields legal: latch year/month/day/sep_sel, go LOAD.
  - start=1 with any field illegal (year 0 or >9999, month 0 or >12, day 0 or >31, sep_sel=3): err=1 next cycle, stay IDLE, no bytes emitted.
  - No per-month day check.
- LOAD (1 cycle): convert latched fields to BCD digits; compute digit counts. No leading zeros: year 1–4 digits, month/day 1–2 digits. Go YEAR.
- Latency: start edge N → LOAD during cycle N..N+1 → out_valid=1 with first year digit after edge N+1.
- YEAR, MONTH, DAY:
  - Emit digits MSD first, as 0x30+digit.
  - Per-state digit index advances only on a transfer (out_valid&&out_ready).
  - After the last digit transfers, advance to the next state.
- SEP1, SEP2: emit one separator byte, advance on transfer.
- After the last DAY digit transfers: out_valid=0 and done=1 for exactly one cycle; return to IDLE.
- Backpressure: while out_valid&&!out_ready, out_char and state are held unchanged. out_valid never drops without a transfer, except on reset.
- out_valid stays high back-to-back across state boundaries: one byte per cycle when out_ready is held 1.
- start while busy is ignored; no queueing, no err.
- start in the same cycle as the done pulse is accepted, since the block is in IDLE that cycle.
- Total bytes = yd+md+dd+2. Min 5 ("1.1.1"), max 10.

Optional Feature:
- DATE_PAD_EN
  - Defined: fixed-width fields. Year always 4 digits, month and day always 2 digits, with leading '0'. Every string is exactly 10 bytes.
  - Undefined: no leading zeros, as above.
  - Validation, timing and handshake are identical in both builds.

Test Plan:
- year=2021, month=10, day=26, sep_sel=0, out_ready=1 → bytes 32 30 32 31 2E 31 30 2E 32 36 on 10 consecutive cycles, first one 2 cycles after start; done pulses once afterwards.
- year=7, month=3, day=5, sep_sel=2 → "7/3/5" (37 2F 33 2F 35); with DATE_PAD_EN → "0007/03/05".
- year=1999, month=12, day=31, sep_sel=1, out_ready toggling 1,0,0,1,... → "1999-12-31". Each byte held stable through stall cycles; no byte dropped or duplicated.
- Illegal starts: month=13, then day=0, then sep_sel=3, then year=10000 → err pulses each time; out_valid stays 0; busy stays 0.
- reset asserted mid-string, after the 4th byte of "2021.10.26" → out_valid=0 and busy=0 immediately. A new start then emits a complete fresh string.
- start pulsed during busy → ignored; in-flight string completes unchanged. start in the done cycle → next string begins without a gap cycle beyond LOAD.
